// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes and
// the select/operation codes driven onto the datapath.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Opcodes without an immediate fall back to the I format.
  function automatic logic [1:0] imm_src_for(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_dec.sv
// Execute-phase ALU decode: maps funct3/funct7b5 to an ALU operation and
// flags funct3 values the core does not implement.
module alu_dec
  import ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_rtype,
  output logic [2:0] alu_ctrl,
  output logic       illegal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (funct3)
      // funct7b5 only selects sub for register forms; for I-type it is immediate bits.
      3'b000:  alu_ctrl = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_ctrl = ALU_SLT;
      3'b110:  alu_ctrl = ALU_OR;
      3'b111:  alu_ctrl = ALU_AND;
      default: illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle RISC-V style datapath.
// Define BRANCH_EXT_EN to support bne/blt/bge/bltu/bgeu in addition to beq.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [6:0] op_in,
  input  logic [2:0] funct3_in,
  input  logic       funct7b5_in,
  input  logic       Z_in,
  input  logic       N_in,
  input  logic       V_in,
  input  logic       C_in,
  input  logic       mem_ready_in,
  output logic [2:0] alu_ctrl_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] result_src_o,
  output logic [1:0] imm_src_o,
  output logic       adr_src_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic       illegal_o,
  output logic [3:0] state_dbg_o
);

  state_t     state, state_next;
  logic [2:0] exec_alu_ctrl;
  logic       exec_illegal;
  logic       branch_legal;
  logic       branch_taken;

  alu_dec u_alu_dec (
    .funct3   (funct3_in),
    .funct7b5 (funct7b5_in),
    .is_rtype (state == EXECR),
    .alu_ctrl (exec_alu_ctrl),
    .illegal  (exec_illegal)
  );

`ifdef BRANCH_EXT_EN
  always_comb begin
    branch_legal = 1'b1;
    branch_taken = 1'b0;
    case (funct3_in)
      3'b000:  branch_taken = Z_in;
      3'b001:  branch_taken = ~Z_in;
      3'b100:  branch_taken = N_in ^ V_in;
      3'b101:  branch_taken = ~(N_in ^ V_in);
      3'b110:  branch_taken = ~C_in;
      3'b111:  branch_taken = C_in;
      default: branch_legal = 1'b0;
    endcase
  end
`else
  logic unused_flags;
  assign unused_flags = ^{N_in, V_in, C_in};
  assign branch_legal = (funct3_in == 3'b000);
  assign branch_taken = Z_in;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= FETCH;
    else        state <= state_next;
  end

  // Memory handshake: the controller holds its request (state and enables)
  // stable; mem_ready_in high in a cycle means the access completes in that
  // cycle, and only then does the FSM advance past a memory state.
  always_comb begin
    state_next   = state;
    alu_ctrl_o   = ALU_ADD;
    alu_src_a_o  = SRCA_PC;
    alu_src_b_o  = SRCB_RS2;
    result_src_o = RES_ALUOUT;
    adr_src_o    = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    illegal_o    = 1'b0;
    case (state)
      FETCH: begin
        alu_src_b_o  = SRCB_FOUR;
        result_src_o = RES_ALURESULT;
        ir_write_o   = mem_ready_in;
        pc_write_o   = mem_ready_in;
        if (mem_ready_in) state_next = DECODE;
      end
      DECODE: begin
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_IMM;
        case (op_in)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_RTYPE:          state_next = EXECR;
          OP_ITYPE:          state_next = EXECI;
          OP_BRANCH:         state_next = branch_legal ? BRANCH : TRAP;
          OP_JAL:            state_next = JAL;
          default:           state_next = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a_o = SRCA_RS1;
        alu_src_b_o = SRCB_IMM;
        state_next  = (op_in == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src_o = 1'b1;
        if (mem_ready_in) state_next = MEMWB;
      end
      MEMWB: begin
        result_src_o = RES_MEMDATA;
        reg_write_o  = 1'b1;
        state_next   = FETCH;
      end
      MEMWRITE: begin
        adr_src_o   = 1'b1;
        mem_write_o = 1'b1;
        if (mem_ready_in) state_next = FETCH;
      end
      EXECR, EXECI: begin
        alu_src_a_o = SRCA_RS1;
        alu_src_b_o = (state == EXECR) ? SRCB_RS2 : SRCB_IMM;
        alu_ctrl_o  = exec_alu_ctrl;
        state_next  = exec_illegal ? TRAP : ALUWB;
      end
      ALUWB: begin
        reg_write_o = 1'b1;
        state_next  = FETCH;
      end
      BRANCH: begin
        alu_src_a_o = SRCA_RS1;
        alu_src_b_o = SRCB_RS2;
        alu_ctrl_o  = ALU_SUB;
        pc_write_o  = branch_taken;
        state_next  = FETCH;
      end
      JAL: begin
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_FOUR;
        pc_write_o  = 1'b1;
        state_next  = ALUWB;
      end
      TRAP:    illegal_o  = 1'b1;
      default: state_next = TRAP;
    endcase
    // Reset kills every side effect of the cycle it is sampled in.
    if (rst_in) begin
      ir_write_o  = 1'b0;
      pc_write_o  = 1'b0;
      mem_write_o = 1'b0;
      reg_write_o = 1'b0;
      illegal_o   = 1'b0;
    end
  end

  assign imm_src_o   = imm_src_for(op_in);
  assign state_dbg_o = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a per-instruction phase model
// drives an expected queue checked every cycle, plus literal pulse counts.
`timescale 1ns/1ps
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  localparam int W     = 21;
  localparam int P_ST  = 17;
  localparam int P_ALU = 14;
  localparam int P_A   = 12;
  localparam int P_B   = 10;
  localparam int P_RS  = 8;
  localparam int P_IMM = 6;
  localparam int P_ADR = 5;
  localparam int P_IR  = 4;
  localparam int P_PC  = 3;
  localparam int P_MW  = 2;
  localparam int P_RW  = 1;
  localparam int P_ILL = 0;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_in, funct7b5_in, z_in, n_in, v_in, c_in, mem_ready_in;
  logic [6:0] op_in;
  logic [2:0] funct3_in;
  logic [2:0] alu_ctrl_o;
  logic [1:0] alu_src_a_o, alu_src_b_o, result_src_o, imm_src_o;
  logic       adr_src_o, ir_write_o, pc_write_o, mem_write_o, reg_write_o, illegal_o;
  logic [3:0] state_dbg_o;

  multicycle_ctrl dut (
    .clk_in(clk), .rst_in(rst_in), .op_in(op_in), .funct3_in(funct3_in),
    .funct7b5_in(funct7b5_in), .Z_in(z_in), .N_in(n_in), .V_in(v_in), .C_in(c_in),
    .mem_ready_in(mem_ready_in), .alu_ctrl_o(alu_ctrl_o), .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o(alu_src_b_o), .result_src_o(result_src_o), .imm_src_o(imm_src_o),
    .adr_src_o(adr_src_o), .ir_write_o(ir_write_o), .pc_write_o(pc_write_o),
    .mem_write_o(mem_write_o), .reg_write_o(reg_write_o), .illegal_o(illegal_o),
    .state_dbg_o(state_dbg_o)
  );

  logic [W-1:0] dut_vec;
  assign dut_vec = {state_dbg_o, alu_ctrl_o, alu_src_a_o, alu_src_b_o, result_src_o,
                    imm_src_o, adr_src_o, ir_write_o, pc_write_o, mem_write_o,
                    reg_write_o, illegal_o};

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mask_q[$];
  string        tag_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cnt_rw = 0, cnt_pc = 0, cnt_mw = 0, cnt_ill = 0, cnt_memread = 0, cnt_busy = 0;

  // model state for the instruction being issued
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f7b5;
  logic [3:0] cur_znvc;
  state_t     ph_q[$];
  logic       rd_q[$];
  bit         model_trapped;
  logic [W-1:0] e_tmp, m_tmp;

  function automatic bit model_alu(input logic [2:0] f3, input bit is_r,
                                   input logic f7b5, output int code);
    code = 0;
    case (f3)
      3'b000:  code = (is_r && f7b5) ? 1 : 0;
      3'b010:  code = 5;
      3'b110:  code = 3;
      3'b111:  code = 2;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  function automatic bit model_branch(input logic [2:0] f3, input logic [3:0] f,
                                      output bit taken);
    bit z, n, v, c;
    {z, n, v, c} = f;
    taken = z;
`ifdef BRANCH_EXT_EN
    case (f3)
      3'b000:  taken = z;
      3'b001:  taken = !z;
      3'b100:  taken = (n != v);
      3'b101:  taken = (n == v);
      3'b110:  taken = !c;
      3'b111:  taken = c;
      default: return 1'b0;
    endcase
    return 1'b1;
`else
    return (f3 == 3'b000);
`endif
  endfunction

  function automatic void setf(input int lsb, input int w, input int val);
    for (int k = 0; k < w; k++) begin
      e_tmp[lsb+k] = val[k];
      m_tmp[lsb+k] = 1'b1;
    end
  endfunction

  function automatic void push_exp(input string tag, input state_t ph, input logic rdy,
                                   input logic rst, input bit state_known);
    int  code;
    bit  taken;
    e_tmp = '0;
    m_tmp = '0;
    if (state_known) setf(P_ST, 4, int'(ph));
    setf(P_IR, 1, 0); setf(P_PC, 1, 0); setf(P_MW, 1, 0); setf(P_RW, 1, 0); setf(P_ILL, 1, 0);
    case (cur_op)
      7'b0000011, 7'b0010011: setf(P_IMM, 2, 0);
      7'b0100011:             setf(P_IMM, 2, 1);
      7'b1100011:             setf(P_IMM, 2, 2);
      7'b1101111:             setf(P_IMM, 2, 3);
      default: ;
    endcase
    if (!rst) begin
      case (ph)
        FETCH: begin
          setf(P_ADR, 1, 0); setf(P_A, 2, 0); setf(P_B, 2, 2); setf(P_ALU, 3, 0);
          setf(P_RS, 2, 2); setf(P_IR, 1, int'(rdy)); setf(P_PC, 1, int'(rdy));
        end
        DECODE:   begin setf(P_A, 2, 1); setf(P_B, 2, 1); setf(P_ALU, 3, 0); end
        MEMADR:   begin setf(P_A, 2, 2); setf(P_B, 2, 1); setf(P_ALU, 3, 0); end
        MEMREAD:  begin setf(P_ADR, 1, 1); setf(P_RS, 2, 0); end
        MEMWB:    begin setf(P_RS, 2, 1); setf(P_RW, 1, 1); end
        MEMWRITE: begin setf(P_ADR, 1, 1); setf(P_RS, 2, 0); setf(P_MW, 1, 1); end
        EXECR, EXECI: begin
          setf(P_A, 2, 2);
          setf(P_B, 2, (ph == EXECR) ? 0 : 1);
          if (model_alu(cur_f3, ph == EXECR, cur_f7b5, code)) setf(P_ALU, 3, code);
        end
        ALUWB:    begin setf(P_RS, 2, 0); setf(P_RW, 1, 1); end
        BRANCH: begin
          void'(model_branch(cur_f3, cur_znvc, taken));
          setf(P_A, 2, 2); setf(P_B, 2, 0); setf(P_ALU, 3, 1); setf(P_RS, 2, 0);
          setf(P_PC, 1, int'(taken));
        end
        JAL: begin
          setf(P_A, 2, 1); setf(P_B, 2, 2); setf(P_ALU, 3, 0); setf(P_RS, 2, 0); setf(P_PC, 1, 1);
        end
        TRAP:     setf(P_ILL, 1, 1);
        default: ;
      endcase
    end
    exp_q.push_back(e_tmp);
    mask_q.push_back(m_tmp);
    tag_q.push_back($sformatf("%s/%s%s", tag, ph.name(), rst ? "+rst" : ""));
  endfunction

  function automatic void add_ph(input state_t s, input logic r);
    ph_q.push_back(s);
    rd_q.push_back(r);
  endfunction

  task automatic check_lit(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  // driver: builds the phase list for one instruction, then plays it out
  task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7b5, input logic [3:0] znvc,
                           input int fetch_wait, input int mem_wait, input int abort_at);
    int code;
    bit ok, taken;
    ph_q.delete();
    rd_q.delete();
    for (int i = 0; i < fetch_wait; i++) add_ph(FETCH, 1'b0);
    add_ph(FETCH, 1'b1);
    add_ph(DECODE, 1'b1);
    case (op)
      7'b0000011: begin
        add_ph(MEMADR, 1'b1);
        for (int i = 0; i < mem_wait; i++) add_ph(MEMREAD, 1'b0);
        add_ph(MEMREAD, 1'b1);
        add_ph(MEMWB, 1'b1);
      end
      7'b0100011: begin
        add_ph(MEMADR, 1'b1);
        for (int i = 0; i < mem_wait; i++) add_ph(MEMWRITE, 1'b0);
        add_ph(MEMWRITE, 1'b1);
      end
      7'b0110011, 7'b0010011: begin
        add_ph((op == 7'b0110011) ? EXECR : EXECI, 1'b1);
        ok = model_alu(f3, op == 7'b0110011, f7b5, code);
        add_ph(ok ? ALUWB : TRAP, 1'b1);
      end
      7'b1100011: begin
        ok = model_branch(f3, znvc, taken);
        add_ph(ok ? BRANCH : TRAP, 1'b1);
      end
      7'b1101111: begin add_ph(JAL, 1'b1); add_ph(ALUWB, 1'b1); end
      default: add_ph(TRAP, 1'b1);
    endcase
    if (ph_q[ph_q.size()-1] == TRAP)
      for (int i = 0; i < 3; i++) add_ph(TRAP, 1'b1);
    model_trapped = (ph_q[ph_q.size()-1] == TRAP) && (abort_at < 0);
    for (int i = 0; i < ph_q.size(); i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        op_in = op; funct3_in = f3; funct7b5_in = f7b5;
        {z_in, n_in, v_in, c_in} = znvc;
        cur_op = op; cur_f3 = f3; cur_f7b5 = f7b5; cur_znvc = znvc;
      end
      if (i == abort_at) begin
        rst_in = 1'b1; mem_ready_in = 1'b1;
        push_exp(tag, ph_q[i], 1'b1, 1'b1, 1'b1);
        break;
      end
      rst_in = 1'b0;
      mem_ready_in = rd_q[i];
      push_exp(tag, ph_q[i], rd_q[i], 1'b0, 1'b1);
    end
    @(negedge clk); #1;
  endtask

  task automatic do_reset(input int n, input bit known, input state_t st);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst_in = 1'b1;
      mem_ready_in = 1'b1;
      push_exp("reset", (i == 0) ? st : FETCH, 1'b1, 1'b1, known || (i > 0));
    end
    @(negedge clk); #1;
  endtask

  task automatic run_checked_branch(input string tag, input logic [2:0] f3, input logic [3:0] znvc);
    run_instr(tag, 7'b1100011, f3, 1'b0, znvc, 0, 0, -1);
    if (model_trapped) do_reset(1, 1'b1, TRAP);
  endtask

  // compare process
  initial begin
    logic [W-1:0] e, m;
    string t;
    forever begin
      @(negedge clk);
      if (reg_write_o) cnt_rw++;
      if (pc_write_o)  cnt_pc++;
      if (mem_write_o) cnt_mw++;
      if (illegal_o)   cnt_ill++;
      if (state_dbg_o == MEMREAD) cnt_memread++;
      if (state_dbg_o != FETCH)   cnt_busy++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        m = mask_q.pop_front();
        t = tag_q.pop_front();
        n_checks++;
        if ((dut_vec & m) !== (e & m)) begin
          n_fail++;
          $display("FAIL %s: got %h required %h (mask %h)", t, dut_vec & m, e & m, m);
        end
      end
    end
  end

  // directed stimulus
  initial begin
    int b_rw, b_pc, b_mw, b_ill, b_mr, b_busy;
    rst_in = 1'b1; op_in = '0; funct3_in = '0; funct7b5_in = 1'b0;
    z_in = 1'b0; n_in = 1'b0; v_in = 1'b0; c_in = 1'b0; mem_ready_in = 1'b1;
    cur_op = '0; cur_f3 = '0; cur_f7b5 = 1'b0; cur_znvc = '0;
    do_reset(2, 1'b0, FETCH);

    b_rw = cnt_rw; b_busy = cnt_busy;
    run_instr("add", 7'b0110011, 3'b000, 1'b0, 4'h0, 0, 0, -1);
    check_lit("add_reg_write_pulses", cnt_rw - b_rw, 1);
    check_lit("add_cycles_outside_fetch", cnt_busy - b_busy, 3);

    run_instr("sub",  7'b0110011, 3'b000, 1'b1, 4'h0, 0, 0, -1);
    run_instr("slt",  7'b0110011, 3'b010, 1'b0, 4'h0, 0, 0, -1);
    run_instr("or",   7'b0110011, 3'b110, 1'b0, 4'h0, 0, 0, -1);
    run_instr("and",  7'b0110011, 3'b111, 1'b0, 4'h0, 0, 0, -1);
    run_instr("addi", 7'b0010011, 3'b000, 1'b1, 4'h0, 0, 0, -1);
    run_instr("slti", 7'b0010011, 3'b010, 1'b0, 4'h0, 0, 0, -1);
    run_instr("andi", 7'b0010011, 3'b111, 1'b0, 4'h0, 0, 0, -1);

    b_rw = cnt_rw; b_mr = cnt_memread;
    run_instr("lw_wait", 7'b0000011, 3'b010, 1'b0, 4'h0, 1, 2, -1);
    check_lit("lw_memread_cycles", cnt_memread - b_mr, 3);
    check_lit("lw_reg_write_pulses", cnt_rw - b_rw, 1);

    b_busy = cnt_busy;
    run_instr("lw", 7'b0000011, 3'b010, 1'b0, 4'h0, 0, 0, -1);
    check_lit("lw_cycles_outside_fetch", cnt_busy - b_busy, 4);

    b_busy = cnt_busy; b_mw = cnt_mw;
    run_instr("sw", 7'b0100011, 3'b010, 1'b0, 4'h0, 0, 0, -1);
    check_lit("sw_cycles_outside_fetch", cnt_busy - b_busy, 3);
    check_lit("sw_mem_write_pulses", cnt_mw - b_mw, 1);
    run_instr("sw_wait", 7'b0100011, 3'b010, 1'b0, 4'h0, 0, 1, -1);

    b_pc = cnt_pc; b_busy = cnt_busy;
    run_instr("beq_z1", 7'b1100011, 3'b000, 1'b0, 4'b1000, 0, 0, -1);
    check_lit("beq_taken_pc_pulses", cnt_pc - b_pc, 2);
    check_lit("beq_cycles_outside_fetch", cnt_busy - b_busy, 2);
    b_pc = cnt_pc;
    run_instr("beq_z0", 7'b1100011, 3'b000, 1'b0, 4'b0000, 0, 0, -1);
    check_lit("beq_not_taken_pc_pulses", cnt_pc - b_pc, 1);

    b_pc = cnt_pc; b_busy = cnt_busy;
    run_instr("jal", 7'b1101111, 3'b000, 1'b0, 4'h0, 0, 0, -1);
    check_lit("jal_pc_pulses", cnt_pc - b_pc, 2);
    check_lit("jal_cycles_outside_fetch", cnt_busy - b_busy, 3);

    b_pc = cnt_pc; b_ill = cnt_ill;
    run_checked_branch("bltu_c0", 3'b110, 4'b0000);
`ifdef BRANCH_EXT_EN
    check_lit("bltu_taken_pc_pulses", cnt_pc - b_pc, 2);
`else
    check_lit("bltu_trap_illegal_cycles", cnt_ill - b_ill, 4);
`endif
    run_checked_branch("bne_z0", 3'b001, 4'b0000);
    run_checked_branch("blt_nv", 3'b100, 4'b0100);
    run_checked_branch("bge_nv", 3'b101, 4'b0100);
    run_checked_branch("bgeu_c1", 3'b111, 4'b0001);
    run_checked_branch("bfunct3_010", 3'b010, 4'b1000);

    run_instr("r_f3_001", 7'b0110011, 3'b001, 1'b0, 4'h0, 0, 0, -1);
    do_reset(1, 1'b1, TRAP);
    run_instr("i_f3_101", 7'b0010011, 3'b101, 1'b0, 4'h0, 0, 0, -1);
    do_reset(1, 1'b1, TRAP);

    b_ill = cnt_ill;
    run_instr("op_7f", 7'b1111111, 3'b000, 1'b0, 4'h0, 0, 0, -1);
    check_lit("op_7f_illegal_cycles", cnt_ill - b_ill, 4);
    do_reset(1, 1'b1, TRAP);
    run_instr("add_after_trap", 7'b0110011, 3'b000, 1'b0, 4'h0, 0, 0, -1);

    b_mw = cnt_mw;
    run_instr("sw_abort", 7'b0100011, 3'b010, 1'b0, 4'h0, 0, 3, 4);
    check_lit("sw_abort_mem_write_pulses", cnt_mw - b_mw, 1);
    run_instr("add_after_abort", 7'b0110011, 3'b000, 1'b0, 4'h0, 0, 0, -1);

    @(negedge clk); #1;
    check_lit("expected_queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
- REQ-001: No parameters; all encodings come from ctrl_pkg.
- REQ-002: clk_in  input  1  system clock; all state changes occur on its rising edge.
- REQ-003: rst_in  input  1  synchronous, active-high reset.
- REQ-004: op_in  input  7  instruction opcode, from the instruction register.
- REQ-005: funct3_in  input  3 / funct7b5_in  input  1  instruction function fields.
- REQ-006: Z_in, N_in, V_in, C_in  input  1 each  ALU flags, sampled combinationally in BRANCH.
- REQ-007: mem_ready_in  input  1  memory handshake; the access completes in the cycle it is high.
- REQ-008: alu_ctrl_o  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- REQ-009: alu_src_a_o  output  2  operand A select: 00 PC, 01 oldPC, 10 rs1.
- REQ-010: alu_src_b_o  output  2  operand B select: 00 rs2, 01 imm, 10 constant 4.
- REQ-011: result_src_o  output  2  result select: 00 aluout, 01 mem data, 10 alu result.
- REQ-012: imm_src_o  output  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- REQ-013: adr_src_o, ir_write_o, pc_write_o, mem_write_o, reg_write_o  output  1 each  datapath enables.
- REQ-014: illegal_o  output  1  sticky trap indicator.

Function
- REQ-015: Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP; outputs decode from state (BRANCH pc_write and EXECR/EXECI alu_ctrl also use the inputs).
- REQ-016: FETCH: adr_src=0, a=00, b=10, add, result_src=10; ir_write and pc_write equal mem_ready_in; hold FETCH until mem_ready_in=1, then go to DECODE.
- REQ-017: DECODE: a=01, b=01, add; next state is MEMADR for opcode 0000011 or 0100011, EXECR for 0110011, EXECI for 0010011, BRANCH for 1100011, JAL for 1101111, otherwise TRAP.
- REQ-018: MEMADR: a=10, b=01, add; next state is MEMREAD for a load or MEMWRITE for a store.
- REQ-019: MEMREAD: adr_src=1, result_src=00; hold until mem_ready_in=1, then go to MEMWB.
- REQ-020: MEMWB: result_src=01, reg_write=1; next state is FETCH.
- REQ-021: MEMWRITE: adr_src=1, result_src=00, mem_write=1 held until mem_ready_in=1; next state is FETCH.
- REQ-022: EXECR: a=10, b=00. EXECI: a=10, b=01. Both go to ALUWB.
- REQ-023: Execute ALU decode by funct3: 000 gives add, or sub when R-type and funct7b5=1; 010 gives slt; 110 gives or; 111 gives and; any other funct3 sends the FSM to TRAP with no write.
- REQ-024: ALUWB: result_src=00, reg_write=1; next state is FETCH.
- REQ-025: BRANCH: a=10, b=00, sub, result_src=00; pc_write=1 only when the branch is taken (REQ-032); next state is FETCH.
- REQ-026: JAL: a=01, b=10, add, result_src=00, pc_write=1; next state is ALUWB.
- REQ-027: imm_src_o decodes combinationally from op_in in every state.
- REQ-028: TRAP: all enables are 0 and illegal_o=1; the FSM stays in TRAP until reset.
- REQ-029: Latency with mem_ready_in held at 1: R-type, I-type, store and jal take 4 cycles; load takes 5; branch takes 3.

Reset
- REQ-030: While rst_in is high (sampled at a clock edge): next state is FETCH, and all enables and illegal_o are 0 during the reset cycle.
- REQ-031: Reset asserted mid-instruction aborts the instruction; no further write enable is asserted for it.

Configuration
- REQ-032: With BRANCH_EXT_EN defined, funct3 selects the take condition: 000 beq (Z), 001 bne (~Z), 100 blt (N^V), 101 bge (~(N^V)), 110 bltu (~C), 111 bgeu (C); funct3 010 or 011 traps.
- REQ-033: With BRANCH_EXT_EN undefined, only beq (funct3 000) is legal; any other branch funct3 goes to TRAP instead of BRANCH.

Structure
- REQ-034: ctrl_pkg holds the state enumeration (4-bit), the opcode constants, and the alu_ctrl, src-select and imm_src encodings.
- REQ-035: Execute ALU decoding (REQ-023) lives in one sub-module, alu_dec.

Verification
- REQ-036: add (op 0110011, f3 000, f7b5 0), ready=1 -> states FETCH, DECODE, EXECR, ALUWB; alu_ctrl=000 in EXECR; reg_write=1 in cycle 4 only.
- REQ-037: lw with ready low for 2 cycles in MEMREAD -> MEMREAD held 3 cycles; reg_write=1 once, with result_src=01.
- REQ-038: beq with Z=1 -> pc_write=1 in BRANCH with alu_ctrl=001; the same instruction with Z=0 -> pc_write=0.
- REQ-039: bltu (f3 110) with C=0 -> taken when BRANCH_EXT_EN is defined; with BRANCH_EXT_EN undefined -> TRAP and illegal_o=1.
- REQ-040: op 1111111 -> TRAP with illegal_o=1 held; then rst_in=1 for one cycle -> FETCH and illegal_o=0.
- REQ-041: rst_in=1 asserted in MEMWRITE -> mem_write=0 in the reset cycle; next state is FETCH.
